// File: rtl/id_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pkg
// Description : Shared widths, register-zero constant and control bundle type
//               for the decode-to-execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CTRL_W = 12;

    // Architectural register that always reads as zero
    localparam int ZERO_REG   = 0;

    typedef logic [DEF_CTRL_W-1:0] ctrl_t;

endpackage : id_ex_pkg
`default_nettype wire

// File: rtl/id_ex_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_if
// Description : Decode-side inputs, write-back port and execute-side bundle of
//               the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_pipe_if
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTRL_W = DEF_CTRL_W
) ();

    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              ex_valid;
    logic [ADDR_W-1:0] ex_rs_addr;
    logic [ADDR_W-1:0] ex_rt_addr;
    logic [ADDR_W-1:0] ex_rd_addr;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output stall, flush, id_valid, rs_addr, rt_addr, rd_addr,
               rs_data, rt_data, imm, ctrl, wb_we, wb_addr, wb_data,
        input  ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr,
               ex_rs_data, ex_rt_data, ex_imm, ex_ctrl
    );

    modport slave (
        input  stall, flush, id_valid, rs_addr, rt_addr, rd_addr,
               rs_data, rt_data, imm, ctrl, wb_we, wb_addr, wb_data,
        output ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr,
               ex_rs_data, ex_rt_data, ex_imm, ex_ctrl
    );

endinterface : id_ex_pipe_if
`default_nettype wire

// File: rtl/id_ex_operand.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_operand
// Description : One source-operand register with register-zero forcing,
//               write-back bypass on load and write-back refresh while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              stall,
    input  wire logic              flush,
    input  wire logic [ADDR_W-1:0] src_addr,
    input  wire logic [DATA_W-1:0] src_data,
    input  wire logic [ADDR_W-1:0] held_addr,
    input  wire logic              wb_we,
    input  wire logic [ADDR_W-1:0] wb_addr,
    input  wire logic [DATA_W-1:0] wb_data,
    output logic      [DATA_W-1:0] data_q
);

    localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (flush) begin
            data_d = '0;
        end else if (stall) begin
            // A write landing on the held source register keeps the operand fresh
            if (wb_we && (wb_addr == held_addr) && (held_addr != C_ZERO_ADDR)) begin
                data_d = wb_data;
            end
        end else if (src_addr == C_ZERO_ADDR) begin
            data_d = '0;
        end else if (wb_we && (wb_addr == src_addr)) begin
            data_d = wb_data;
        end else begin
            data_d = src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule : id_ex_operand
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe
// Description : Decode-to-execute pipeline register with flush, stall and
//               write-back bypass of both source operands.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    id_ex_pipe_if.slave bus
);

    logic              ex_valid_q,   ex_valid_d;
    logic [ADDR_W-1:0] ex_rs_addr_q, ex_rs_addr_d;
    logic [ADDR_W-1:0] ex_rt_addr_q, ex_rt_addr_d;
    logic [ADDR_W-1:0] ex_rd_addr_q, ex_rd_addr_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [DATA_W-1:0] ex_rs_data_q;
    logic [DATA_W-1:0] ex_rt_data_q;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_addr_d = ex_rs_addr_q;
        ex_rt_addr_d = ex_rt_addr_q;
        ex_rd_addr_d = ex_rd_addr_q;
        ex_imm_d     = ex_imm_q;
        ex_ctrl_d    = ex_ctrl_q;
        if (bus.flush) begin
            ex_valid_d   = 1'b0;
            ex_rs_addr_d = '0;
            ex_rt_addr_d = '0;
            ex_rd_addr_d = '0;
            ex_imm_d     = '0;
            ex_ctrl_d    = '0;
        end else if (!bus.stall) begin
            ex_valid_d   = bus.id_valid;
            ex_rs_addr_d = bus.rs_addr;
            ex_rt_addr_d = bus.rt_addr;
            ex_rd_addr_d = bus.rd_addr;
            ex_imm_d     = bus.imm;
            // A bubble must never carry live control into execute
            ex_ctrl_d    = bus.id_valid ? bus.ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rs_addr_q <= '0;
            ex_rt_addr_q <= '0;
            ex_rd_addr_q <= '0;
            ex_imm_q     <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_addr_q <= ex_rs_addr_d;
            ex_rt_addr_q <= ex_rt_addr_d;
            ex_rd_addr_q <= ex_rd_addr_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    id_ex_operand #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_operand (
        .clk       (clk),
        .rst       (rst),
        .stall     (bus.stall),
        .flush     (bus.flush),
        .src_addr  (bus.rs_addr),
        .src_data  (bus.rs_data),
        .held_addr (ex_rs_addr_q),
        .wb_we     (bus.wb_we),
        .wb_addr   (bus.wb_addr),
        .wb_data   (bus.wb_data),
        .data_q    (ex_rs_data_q)
    );

    id_ex_operand #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_operand (
        .clk       (clk),
        .rst       (rst),
        .stall     (bus.stall),
        .flush     (bus.flush),
        .src_addr  (bus.rt_addr),
        .src_data  (bus.rt_data),
        .held_addr (ex_rt_addr_q),
        .wb_we     (bus.wb_we),
        .wb_addr   (bus.wb_addr),
        .wb_data   (bus.wb_data),
        .data_q    (ex_rt_data_q)
    );

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rs_addr = ex_rs_addr_q;
    assign bus.ex_rt_addr = ex_rt_addr_q;
    assign bus.ex_rd_addr = ex_rd_addr_q;
    assign bus.ex_rs_data = ex_rs_data_q;
    assign bus.ex_rt_data = ex_rt_data_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_ctrl    = ex_ctrl_q;

endmodule : id_ex_pipe
`default_nettype wire

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter: DATA_W, default 16, operand/immediate width.
REQ-002 Parameter: ADDR_W, default 4, register address width.
REQ-003 Parameter: CTRL_W, default 12, decoded control bundle width.
REQ-004 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 stall  input  1  hold all captured state.
REQ-008 flush  input  1  insert bubble.
REQ-009 id_valid  input  1  decode stage holds a real instruction.
REQ-010 rs_addr, rt_addr, rd_addr  input  ADDR_W  source/destination register numbers.
REQ-011 rs_data, rt_data  input  DATA_W  register-file read-port values (no internal write bypass).
REQ-012 imm  input  DATA_W  sign-extended immediate.
REQ-013 ctrl  input  CTRL_W  decoded control bundle.
REQ-014 wb_we  input  1  write-back write enable, same cycle as register-file write.
REQ-015 wb_addr  input  ADDR_W; wb_data  input  DATA_W  write-back target and value.
REQ-016 ex_valid  output  1; ex_rs_addr, ex_rt_addr, ex_rd_addr  output  ADDR_W; ex_rs_data, ex_rt_data, ex_imm  output  DATA_W; ex_ctrl  output  CTRL_W  registered execute-stage bundle.

Function
REQ-017 Update priority each edge SHALL be rst > flush > stall > load.
REQ-018 Load (no rst/flush/stall): all ex_* registers SHALL capture the corresponding inputs, ex_valid <= id_valid; one-cycle latency.
REQ-019 Write-through bypass on load: if wb_we and wb_addr == rs_addr and rs_addr != 0, ex_rs_data SHALL capture wb_data instead of rs_data; same rule independently for rt.
REQ-020 Register 0: if rs_addr == 0, ex_rs_data SHALL capture 0 regardless of rs_data or write-back; same for rt.
REQ-021 Stall: ex_valid, addresses, ex_imm, ex_ctrl SHALL hold.
REQ-022 Stall refresh: during stall, if wb_we and wb_addr == ex_rs_addr and ex_rs_addr != 0, ex_rs_data SHALL update to wb_data; same for rt; otherwise hold.
REQ-023 Flush (including flush with stall): ex_valid <= 0, ex_ctrl <= 0; data/address fields SHALL load 0.
REQ-024 ex_ctrl SHALL be forced to 0 whenever captured with id_valid = 0.
REQ-025 Both bypass paths SHALL fire in the same cycle when rs_addr == rt_addr == wb_addr.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 On rst, all outputs SHALL be 0 on the next rising edge, overriding flush, stall and write-back.
REQ-028 Reset mid-stall SHALL discard held instruction; first post-reset edge with rst=0 follows REQ-017.

Structure
REQ-029 Package id_ex_pkg SHALL hold DATA_W, ADDR_W, CTRL_W defaults, ZERO_REG constant, and the ctrl bundle typedef.
REQ-030 Sub-module id_ex_operand: one operand register with zero-force, load bypass and stall refresh; instantiated twice (rs, rt).

Verification
REQ-031 rs_addr=3, rs_data=0x1111, wb_we=1, wb_addr=3, wb_data=0xBEEF, load -> ex_rs_data=0xBEEF next cycle.
REQ-032 Stall 2 cycles holding ex_rt_addr=5 with wb_we=1, wb_addr=5, wb_data=0x0042 in cycle 2 -> ex_rt_data=0x0042, ex_ctrl unchanged, ex_valid=1.
REQ-033 rs_addr=0, rs_data=0xFFFF, wb_we=1, wb_addr=0, wb_data=0x1234 -> ex_rs_data=0x0000.
REQ-034 flush=1 and stall=1 same cycle, id_valid=1, ctrl=0xABC -> ex_valid=0, ex_ctrl=0.
REQ-035 rst=1 during stall with ex_valid=1 -> all outputs 0 next edge; rst=0, id_valid=1, imm=0x0007 -> ex_imm=0x0007, ex_valid=1.
REQ-036 rs_addr=rt_addr=wb_addr=7, wb_data=0x5A5A -> ex_rs_data=ex_rt_data=0x5A5A.
